// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, unit constants and the A..P letter table.
package morse_pkg;

   localparam int unsigned TBL_W  = 16;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned DOT_U  = 1;
   localparam int unsigned DASH_U = 3;
   localparam int unsigned IGAP_U = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [TBL_W-1:0] pat;
      logic [LEN_W-1:0] len;
   } morse_ent_t;

   // Expand n elements (dashes given MSB-first, 1 = dash) into a left-aligned key pattern.
   function automatic morse_ent_t morse_build(input int unsigned n, input logic [3:0] dashes);
      logic [TBL_W-1:0] p;
      logic [LEN_W-1:0] l;
      logic [3:0]       d;
      morse_ent_t       e;
      p = '0;
      l = '0;
      d = dashes;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i < n) begin
            if (i != 0) begin
               p = p << IGAP_U;
               l = l + LEN_W'(IGAP_U);
            end
            if (d[3]) begin
               p = (p << DASH_U) | ((TBL_W'(1) << DASH_U) - TBL_W'(1));
               l = l + LEN_W'(DASH_U);
            end else begin
               p = (p << DOT_U) | ((TBL_W'(1) << DOT_U) - TBL_W'(1));
               l = l + LEN_W'(DOT_U);
            end
            d = d << 1;
         end
      end
      e.pat = p << (TBL_W - 32'(l));
      e.len = l;
      return e;
   endfunction

   // Codes past P have no pattern and report length 0.
   function automatic morse_ent_t morse_lookup(input int unsigned code);
      morse_ent_t e;
      e = '0;
      case (code)
         0:       e = morse_build(2, 4'b0100);  // A .-
         1:       e = morse_build(4, 4'b1000);  // B -...
         2:       e = morse_build(4, 4'b1010);  // C -.-.
         3:       e = morse_build(3, 4'b1000);  // D -..
         4:       e = morse_build(1, 4'b0000);  // E .
         5:       e = morse_build(4, 4'b0010);  // F ..-.
         6:       e = morse_build(3, 4'b1100);  // G --.
         7:       e = morse_build(4, 4'b0000);  // H ....
         8:       e = morse_build(2, 4'b0000);  // I ..
         9:       e = morse_build(4, 4'b0111);  // J .---
         10:      e = morse_build(3, 4'b1010);  // K -.-
         11:      e = morse_build(4, 4'b0100);  // L .-..
         12:      e = morse_build(2, 4'b1100);  // M --
         13:      e = morse_build(2, 4'b1000);  // N -.
         14:      e = morse_build(3, 4'b1110);  // O ---
         15:      e = morse_build(4, 4'b0110);  // P .--.
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit-rate divider: counts CLK_DIV-1 down to 0, pulses tick at 0 and wraps.
module morse_unit_tick #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic ClockIn,
   input  logic Resetn,
   input  logic reload,
   output logic tick
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         cnt_q <= '0;
      end else if (reload || (cnt_q == '0)) begin
         cnt_q <= CNT_TOP;
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/morse_tx.sv
// Morse letter transmitter: keys a latched letter's pattern, then an inter-letter gap.
// PAT_W must be at least the 16-bit table width.
module morse_tx
   import morse_pkg::*;
#(
   parameter int unsigned CLK_DIV = 250,
   parameter int unsigned SYM_W   = 4,
   parameter int unsigned PAT_W   = 16,
   parameter int unsigned GAP_U   = 3
) (
   input  logic             ClockIn,
   input  logic             Resetn,
   input  logic             Start,
   input  logic [SYM_W-1:0] Letter,
   input  logic             Repeat,
   input  logic             Stop,
   output logic             DotDashOut,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned IDX_W = $clog2(PAT_W + 1);
   localparam int unsigned GAP_W = $clog2(GAP_U + 1);

   state_t           state_q, state_nxt;
   logic [SYM_W-1:0] letter_q, letter_nxt, sel_c;
   logic [PAT_W-1:0] pat_q, pat_nxt, tbl_pat_c;
   logic [IDX_W-1:0] len_q, len_nxt, idx_q, idx_nxt, tbl_len_c;
   logic [GAP_W-1:0] gap_q, gap_nxt;
   logic             dot_nxt, busy_nxt, done_nxt;
   logic             load_c, reload_c, tick;
   morse_ent_t       ent_c;

   morse_unit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .ClockIn (ClockIn),
      .Resetn  (Resetn),
      .reload  (reload_c),
      .tick    (tick)
   );

   // In IDLE the index is the letter being latched this cycle, so the first unit is not delayed.
   always_comb begin
      sel_c     = (state_q == ST_IDLE) ? Letter : letter_q;
      ent_c     = morse_lookup(32'(sel_c));
      tbl_pat_c = PAT_W'(ent_c.pat) << (PAT_W - TBL_W);
      tbl_len_c = IDX_W'(ent_c.len);
   end

   always_comb begin
      state_nxt  = state_q;
      letter_nxt = letter_q;
      pat_nxt    = pat_q;
      len_nxt    = len_q;
      idx_nxt    = idx_q;
      gap_nxt    = gap_q;
      dot_nxt    = DotDashOut;
      busy_nxt   = Busy;
      done_nxt   = 1'b0;
      load_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dot_nxt  = 1'b0;
            busy_nxt = 1'b0;
            if (Start) begin
               letter_nxt = Letter;
               busy_nxt   = 1'b1;
               load_c     = 1'b1;
            end
         end
         ST_SEND: begin
            if (Stop) begin
               state_nxt = ST_IDLE;
               dot_nxt   = 1'b0;
               busy_nxt  = 1'b0;
            end else if (tick) begin
               if (idx_q == len_q - IDX_W'(1)) begin
                  state_nxt = ST_GAP;
                  dot_nxt   = 1'b0;
                  gap_nxt   = '0;
               end else begin
                  idx_nxt = idx_q + IDX_W'(1);
                  dot_nxt = pat_q[PAT_W-1];
                  pat_nxt = pat_q << 1;
               end
            end
         end
         ST_GAP: begin
            if (Stop) begin
               state_nxt = ST_IDLE;
               dot_nxt   = 1'b0;
               busy_nxt  = 1'b0;
            end else if (tick) begin
               if (gap_q == GAP_W'(GAP_U - 1)) begin
                  done_nxt = 1'b1;
                  if (Repeat) begin
                     load_c = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                     busy_nxt  = 1'b0;
                  end
               end else begin
                  gap_nxt = gap_q + GAP_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            dot_nxt   = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
      // Start of a letter (fresh or repeated); an empty letter goes straight to the gap.
      if (load_c) begin
         len_nxt = tbl_len_c;
         idx_nxt = '0;
         gap_nxt = '0;
         pat_nxt = tbl_pat_c << 1;
         if (tbl_len_c == '0) begin
            state_nxt = ST_GAP;
            dot_nxt   = 1'b0;
         end else begin
            state_nxt = ST_SEND;
            dot_nxt   = tbl_pat_c[PAT_W-1];
         end
      end
   end

   assign reload_c = (state_nxt != state_q) || load_c;

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= ST_IDLE;
         letter_q   <= '0;
         pat_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         DotDashOut <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         letter_q   <= letter_nxt;
         pat_q      <= pat_nxt;
         len_q      <= len_nxt;
         idx_q      <= idx_nxt;
         gap_q      <= gap_nxt;
         DotDashOut <= dot_nxt;
         Busy       <= busy_nxt;
         Done       <= done_nxt;
      end
   end

endmodule
